// File: rtl/arty_reset_sequencer.sv
// -----------------------------------------------------------------------------
// arty_reset_sequencer
//   Multi-channel reset sequencer placed after the clock wizard. Waits for a
//   stable MMCM lock with no external reset request, holds every downstream
//   reset for C_HOLD_CYCLES, then releases channels in ascending index order
//   spaced C_RELEASE_GAP cycles apart. Losing lock or seeing a reset request
//   at any point after WAIT_LOCK reasserts every channel and restarts.
//
// Ports
//   i_clk_mhz        system clock
//   i_rst_mhz        synchronous active-high reset
//   i_mmcm_locked    MMCM lock (asynchronous, synchronized internally)
//   i_ext_rst_req    external reset request level (asynchronous, active-high)
//   o_rst_chan       per-channel active-high reset, bit 0 released first
//   o_ready          high once every channel is released
//   o_lock_loss_cnt  saturating count of aborts taken from RUN
//   o_lock_timeout   sticky lock watchdog flag
//
// Build option
//   ARTY_RESET_SEQ_LOCK_WDT_EN : builds the lock watchdog; when undefined
//   o_lock_timeout is tied low and no watchdog logic exists.
// -----------------------------------------------------------------------------
module arty_reset_sequencer #(
  parameter int unsigned C_CHANNELS     = 3,
  parameter int unsigned C_SYNC_STAGES  = 2,
  parameter int unsigned C_HOLD_CYCLES  = 14,
  parameter int unsigned C_RELEASE_GAP  = 8,
  parameter int unsigned C_LOCK_TIMEOUT = 1000000
) (
  input  logic                  i_clk_mhz,
  input  logic                  i_rst_mhz,
  input  logic                  i_mmcm_locked,
  input  logic                  i_ext_rst_req,
  output logic [C_CHANNELS-1:0] o_rst_chan,
  output logic                  o_ready,
  output logic [7:0]            o_lock_loss_cnt,
  output logic                  o_lock_timeout
);

  localparam int unsigned HOLD_W = $clog2((C_HOLD_CYCLES < 2) ? 2 : C_HOLD_CYCLES);
  localparam int unsigned GAP_W  = $clog2((C_RELEASE_GAP < 2) ? 2 : C_RELEASE_GAP);
  localparam int unsigned IDX_W  = $clog2((C_CHANNELS    < 2) ? 2 : C_CHANNELS);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(C_HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(C_RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(C_CHANNELS - 1);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic [C_SYNC_STAGES-1:0] lock_sync;
  logic [C_SYNC_STAGES-1:0] req_sync;
  logic                     s_lock;
  logic                     s_req;

  logic [1:0]            state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [IDX_W-1:0]      rel_idx;
  logic [C_CHANNELS-1:0] rst_chan;
  logic                  ready;
  logic [7:0]            loss_cnt;
  logic                  abort;

  assign s_lock = lock_sync[C_SYNC_STAGES-1];
  assign s_req  = req_sync[C_SYNC_STAGES-1];

  // WAIT_LOCK simply keeps waiting, so only the later states can abort.
  assign abort = (state != ST_WAIT_LOCK) && (!s_lock || s_req);

  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      lock_sync <= '0;
      req_sync  <= '0;
      state     <= ST_WAIT_LOCK;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      rel_idx   <= '0;
      rst_chan  <= '1;
      ready     <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      lock_sync <= {lock_sync[C_SYNC_STAGES-2:0], i_mmcm_locked};
      req_sync  <= {req_sync[C_SYNC_STAGES-2:0], i_ext_rst_req};

      if (abort) begin
        // Abort wins over any terminal count landing on the same edge.
        state    <= ST_WAIT_LOCK;
        hold_cnt <= '0;
        gap_cnt  <= '0;
        rel_idx  <= '0;
        rst_chan <= '1;
        ready    <= 1'b0;
        if (state == ST_RUN && loss_cnt != 8'hFF)
          loss_cnt <= loss_cnt + 8'd1;
      end else begin
        case (state)
          ST_WAIT_LOCK: begin
            rst_chan <= '1;
            ready    <= 1'b0;
            if (s_lock && !s_req) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end

          ST_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt    <= '0;
              rst_chan[0] <= 1'b0;
              if (C_CHANNELS == 1) begin
                state <= ST_RUN;
                ready <= 1'b1;
              end else begin
                state   <= ST_RELEASE;
                rel_idx <= IDX_W'(1);
                gap_cnt <= '0;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end

          ST_RELEASE: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              // Compare-per-bit avoids a variable index narrower/wider than the vector.
              for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                if (rel_idx == IDX_W'(i))
                  rst_chan[i] <= 1'b0;
              end
              if (rel_idx == IDX_LAST) begin
                state   <= ST_RUN;
                ready   <= 1'b1;
                rel_idx <= '0;
              end else begin
                rel_idx <= rel_idx + IDX_W'(1);
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end

          ST_RUN: begin
          end

          default: state <= ST_WAIT_LOCK;
        endcase
      end
    end
  end

  assign o_rst_chan      = rst_chan;
  assign o_ready         = ready;
  assign o_lock_loss_cnt = loss_cnt;

`ifdef ARTY_RESET_SEQ_LOCK_WDT_EN
  localparam int unsigned WDT_W = $clog2((C_LOCK_TIMEOUT < 2) ? 2 : C_LOCK_TIMEOUT);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(C_LOCK_TIMEOUT - 1);

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_flag;

  // Flag is informational only; it never influences the FSM.
  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b0;
    end else if (state == ST_WAIT_LOCK) begin
      if (wdt_cnt == WDT_LAST) begin
        wdt_cnt  <= '0;
        wdt_flag <= 1'b1;
      end else begin
        wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
    end else begin
      wdt_cnt <= '0;
    end
  end

  assign o_lock_timeout = wdt_flag;
`else
  assign o_lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arty_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_arty_reset_sequencer
//   Directed bench for arty_reset_sequencer with default channel/hold/gap
//   settings and C_LOCK_TIMEOUT=100. Edge numbers count posedges after the
//   input change; outputs are sampled 1 time unit after each posedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arty_reset_sequencer;

`ifdef ARTY_RESET_SEQ_LOCK_WDT_EN
  localparam bit WDT_BUILT = 1'b1;
`else
  localparam bit WDT_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       req = 1'b0;
  logic [2:0] rst_chan;
  logic       ready;
  logic [7:0] loss_cnt;
  logic       lock_to;

  int vectors = 0;
  int miscompares = 0;

  arty_reset_sequencer #(
    .C_CHANNELS    (3),
    .C_SYNC_STAGES (2),
    .C_HOLD_CYCLES (14),
    .C_RELEASE_GAP (8),
    .C_LOCK_TIMEOUT(100)
  ) dut (
    .i_clk_mhz      (clk),
    .i_rst_mhz      (rst),
    .i_mmcm_locked  (lock),
    .i_ext_rst_req  (req),
    .o_rst_chan     (rst_chan),
    .o_ready        (ready),
    .o_lock_loss_cnt(loss_cnt),
    .o_lock_timeout (lock_to)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL time_limit: got no finish, expected finish before 2ms");
    $fatal(1, "time limit");
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] ch, input logic rdy, input logic [7:0] cnt);
    chk({tag, ".chan"}, {29'd0, rst_chan}, {29'd0, ch});
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, rdy});
    chk({tag, ".cnt"}, {24'd0, loss_cnt}, {24'd0, cnt});
  endtask

  // Full release from first edge seeing lock/request-clear, checked around
  // each transition edge: 17, 25, 33.
  task automatic release_seq(input string tag, input logic [7:0] cnt);
    edges(16); chk_state({tag, "@16"}, 3'b111, 1'b0, cnt);
    edges(1);  chk_state({tag, "@17"}, 3'b110, 1'b0, cnt);
    edges(7);  chk_state({tag, "@24"}, 3'b110, 1'b0, cnt);
    edges(1);  chk_state({tag, "@25"}, 3'b100, 1'b0, cnt);
    edges(7);  chk_state({tag, "@32"}, 3'b100, 1'b0, cnt);
    edges(1);  chk_state({tag, "@33"}, 3'b000, 1'b1, cnt);
  endtask

  initial begin
    // Reset values
    edges(3);
    chk_state("reset", 3'b111, 1'b0, 8'd0);
    chk("reset.timeout", {31'd0, lock_to}, 32'd0);

    // 1: release reset with lock already high
    rst = 1'b0; lock = 1'b1;
    release_seq("t1", 8'd0);
    edges(10); chk_state("t1.stable", 3'b000, 1'b1, 8'd0);

    // 2: lock drops for 5 cycles from RUN
    lock = 1'b0;
    edges(2); chk_state("t2@2", 3'b000, 1'b1, 8'd0);
    edges(1); chk_state("t2@3", 3'b111, 1'b0, 8'd1);
    edges(2);
    lock = 1'b1;
    release_seq("t2.relock", 8'd1);

    // 1-cycle reset from RUN clears the loss counter
    rst = 1'b1;
    edges(1); chk_state("rst_run", 3'b111, 1'b0, 8'd0);
    rst = 1'b0;
    edges(17); chk_state("t3.pre", 3'b110, 1'b0, 8'd0);

    // 3: external request pulse during RELEASE after channel 0 is out
    edges(2);
    req = 1'b1;
    edges(2); chk_state("t3@2", 3'b110, 1'b0, 8'd0);
    edges(1); chk_state("t3@3", 3'b111, 1'b0, 8'd0);
    req = 1'b0;
    release_seq("t3.rerun", 8'd0);

    // 5: 1-cycle reset while in HOLD
    lock = 1'b0;
    edges(3); chk_state("t5.drop", 3'b111, 1'b0, 8'd1);
    lock = 1'b1;
    edges(8);
    rst = 1'b1;
    edges(1); chk_state("t5.rst", 3'b111, 1'b0, 8'd0);
    rst = 1'b0;
    release_seq("t5.restart", 8'd0);

    // 4: 300 aborts from RUN; counter saturates at 255
    for (int n = 1; n <= 300; n++) begin
      lock = 1'b0;
      edges(3);
      chk("t4.cnt", {24'd0, loss_cnt}, (n > 255) ? 32'd255 : n);
      lock = 1'b1;
      edges(33);
    end
    chk_state("t4.final", 3'b000, 1'b1, 8'd255);

    // 6: lock watchdog (flag stays 0 when the watchdog is not built)
    rst = 1'b1; lock = 1'b0;
    edges(1);
    rst = 1'b0;
    edges(99);  chk("t6@99", {31'd0, lock_to}, 32'd0);
    edges(1);   chk("t6@100", {31'd0, lock_to}, {31'd0, WDT_BUILT});
    chk_state("t6.wait", 3'b111, 1'b0, 8'd0);
    lock = 1'b1;
    edges(33);  chk_state("t6.run", 3'b000, 1'b1, 8'd0);
    chk("t6.sticky", {31'd0, lock_to}, {31'd0, WDT_BUILT});
    rst = 1'b1;
    edges(1);   chk("t6.cleared", {31'd0, lock_to}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
